s_key_scheduler: RTL

Second stage of the RC4 core. After the S-array initializer has filled S memory with the identity permutation (s[k] = k), this block runs the key-scheduling pass: for i = 0..255, j = j + s[i] + key[i mod KEY_BYTES], then s[i] and s[j] are swapped. It drives the same single-port 256x8 S memory through the top-level mux. Its one-cycle `done` pulse hands S memory over to the keystream/decrypt stage.

---
 rtl/s_key_scheduler_if.sv | 35 +++
 rtl/s_key_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/s_key_scheduler_if.sv
// S-memory side bus of the RC4 key scheduler: start/key handshake plus the
// single-port 256x8 S memory address/data/write-enable/read-data signals.
interface s_key_scheduler_if #(
  parameter int KEY_BYTES = 3
);
  logic                   start;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic [7:0]             s_read_data;
  logic [7:0]             address;
  logic [7:0]             data;
  logic                   s_mem_wren;
  logic                   done;

  // Upstream controller plus S memory: drives start/key and memory q.
  modport master (
    output start,
    output secret_key,
    output s_read_data,
    input  address,
    input  data,
    input  s_mem_wren,
    input  done
  );

  // Key scheduler: consumes start/key/q, drives the memory port and done.
  modport slave (
    input  start,
    input  secret_key,
    input  s_read_data,
    output address,
    output data,
    output s_mem_wren,
    output done
  );
endinterface

// File: rtl/s_key_scheduler.sv
// RC4 key-scheduling pass over an S memory that already holds the identity
// permutation. Each iteration reads s[i], updates j, reads s[j], then writes
// s[i] and s[j] back swapped. Memory read data arrives one cycle after the
// address, so every read is a present-address / capture pair of states.
module s_key_scheduler #(
  parameter int KEY_BYTES = 3
) (
  input  logic           clk,
  input  logic           rst,
  s_key_scheduler_if.slave bus
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE,
    READ_I,
    CAPTURE_I,
    READ_J,
    CAPTURE_J,
    WRITE_I,
    WRITE_J,
    INCREMENT,
    DONE
  } state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             i_reg, i_next;
  logic [7:0]             j_reg, j_next;
  logic [7:0]             si_reg, si_next;
  logic [7:0]             sj_reg, sj_next;
  logic [KW-1:0]          k_reg, k_next;
  logic [8*KEY_BYTES-1:0] key_q_reg, key_q_next;

  logic [7:0]             key_bytes [KEY_BYTES];
  logic [7:0]             key_byte;

  logic [7:0]             address_c;
  logic [7:0]             data_c;
  logic                   wren_c;
  logic                   done_c;

  // Byte 0 of the key is the most significant byte of the latched key.
  generate
    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_bytes
      assign key_bytes[gi] = key_q_reg[8*KEY_BYTES-1-8*gi -: 8];
    end
  endgenerate

  assign key_byte = key_bytes[k_reg];

  // State and datapath registers; reset abandons any pass in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      si_reg    <= '0;
      sj_reg    <= '0;
      k_reg     <= '0;
      key_q_reg <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      si_reg    <= si_next;
      sj_reg    <= sj_next;
      k_reg     <= k_next;
      key_q_reg <= key_q_next;
    end
  end

  // Next-state, datapath updates and memory-port decode from the state.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    si_next    = si_reg;
    sj_next    = sj_reg;
    k_next     = k_reg;
    key_q_next = key_q_reg;
    address_c  = 8'd0;
    data_c     = 8'd0;
    wren_c     = 1'b0;
    done_c     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          i_next     = 8'd0;
          j_next     = 8'd0;
          k_next     = '0;
          key_q_next = bus.secret_key;
          state_next = READ_I;
        end
      end
      READ_I: begin
        address_c  = i_reg;
        state_next = CAPTURE_I;
      end
      CAPTURE_I: begin
        // Carries drop: j wraps modulo 256 by construction.
        address_c  = i_reg;
        si_next    = bus.s_read_data;
        j_next     = j_reg + bus.s_read_data + key_byte;
        state_next = READ_J;
      end
      READ_J: begin
        address_c  = j_reg;
        state_next = CAPTURE_J;
      end
      CAPTURE_J: begin
        address_c  = j_reg;
        sj_next    = bus.s_read_data;
        state_next = WRITE_I;
      end
      WRITE_I: begin
        address_c  = i_reg;
        data_c     = sj_reg;
        wren_c     = 1'b1;
        state_next = WRITE_J;
      end
      WRITE_J: begin
        // When i == j this rewrites the same cell with si == sj: a no-op swap.
        address_c  = j_reg;
        data_c     = si_reg;
        wren_c     = 1'b1;
        state_next = INCREMENT;
      end
      INCREMENT: begin
        if (i_reg == 8'd255) begin
          state_next = DONE;
        end else begin
          i_next     = i_reg + 8'd1;
          k_next     = (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
          state_next = READ_I;
        end
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.address    = address_c;
  assign bus.data       = data_c;
  assign bus.s_mem_wren = wren_c;
  assign bus.done       = done_c;

endmodule
